// File: rtl/mem_copy_dma.sv
// Single-port memory copy engine (optional constant fill when DMA_FILL_EN is defined).
// Latency: 2 cycles/word copy (1 cycle/word fill) plus one FINISH cycle; done pulses in FINISH.
// Backpressure: none; start is ignored while busy, abort drops back to IDLE without done.
module mem_copy_dma #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
`ifdef DMA_FILL_EN
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_FINISH} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src_q, dst_q, rem_q, hold_addr_q;
    logic [DATA_W-1:0] data_q;

`ifdef DMA_FILL_EN
    logic fill_q;
    logic fill_start;
    assign fill_start = fill_mode;
`else
    logic fill_q;
    logic fill_start;
    assign fill_q     = 1'b0;
    assign fill_start = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (length == '0)   state_nxt = S_FINISH;
                    else if (fill_start) state_nxt = S_WRITE;
                    else                 state_nxt = S_READ;
                end
            end
            S_READ:   state_nxt = abort ? S_IDLE : S_WRITE;
            S_WRITE: begin
                if (abort)                       state_nxt = S_IDLE;
                else if (rem_q == ADDR_W'(1))    state_nxt = S_FINISH;
                else if (fill_q)                 state_nxt = S_WRITE;
                else                             state_nxt = S_READ;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // hold_addr_q remembers the last driven address so the bus is stable while idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            data_q      <= '0;
            hold_addr_q <= '0;
`ifdef DMA_FILL_EN
            fill_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        rem_q <= length;
`ifdef DMA_FILL_EN
                        fill_q <= fill_mode;
                        if (fill_mode) data_q <= fill_value;
`endif
                    end
                end
                S_READ: begin
                    data_q      <= mem_read_data;
                    hold_addr_q <= src_q;
                end
                S_WRITE: begin
                    src_q       <= src_q + ADDR_W'(1);
                    dst_q       <= dst_q + ADDR_W'(1);
                    rem_q       <= rem_q - ADDR_W'(1);
                    hold_addr_q <= dst_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy             = (state != S_IDLE);
        done             = (state == S_FINISH);
        mem_write_enable = (state == S_WRITE);
        mem_write_data   = data_q;
        case (state)
            S_READ:  mem_address = src_q;
            S_WRITE: mem_address = dst_q;
            default: mem_address = hold_addr_q;
        endcase
    end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter: DATA_W, default 16, memory data width in bits.
REQ-002 Parameter: ADDR_W, default 16, memory address width in bits.
REQ-003 Port: clock  input  1  sole clock; all state changes on posedge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  single-cycle request to begin a transfer.
REQ-006 Port: src_addr  input  ADDR_W  first source word address, sampled on accepted start.
REQ-007 Port: dst_addr  input  ADDR_W  first destination word address, sampled on accepted start.
REQ-008 Port: length  input  ADDR_W  word count, sampled on accepted start.
REQ-009 Port: abort  input  1  terminate the active transfer.
REQ-010 Port: busy  output  1  high from the cycle after an accepted start until the return to IDLE.
REQ-011 Port: done  output  1  one-cycle pulse when a transfer completes normally.
REQ-012 Port: mem_address  output  ADDR_W  address to one memory port.
REQ-013 Port: mem_write_data  output  DATA_W  write data to the memory port.
REQ-014 Port: mem_write_enable  output  1  write strobe to the memory port.
REQ-015 Port: mem_read_data  input  DATA_W  memory read data, registered by memory on negedge.

Function
REQ-016 The block SHALL be a single-port initiator for the team RAM: address is driven after posedge, the memory registers data on the following negedge, and data is captured at the next posedge.
REQ-017 States SHALL be IDLE, READ, WRITE, FINISH; every output SHALL be a function of registered state only (no input-to-output combinational path).
REQ-018 IDLE: start=1 with length!=0 -> READ; start=1 with length==0 -> FINISH with no memory access; start=1 while not IDLE SHALL be ignored.
REQ-019 READ: mem_address=current src, mem_write_enable=0; at posedge capture mem_read_data into data register -> WRITE.
REQ-020 WRITE: mem_address=current dst, mem_write_data=data register, mem_write_enable=1 for exactly one cycle; at posedge src+1, dst+1, remaining-1; remaining reaching 0 -> FINISH, else -> READ.
REQ-021 Copy throughput SHALL be exactly 2 cycles per word; a length-N copy SHALL hold busy for 2N+1 cycles (including FINISH).
REQ-022 FINISH: done=1, busy=1 for one cycle -> IDLE.
REQ-023 Address increments SHALL wrap modulo 2^ADDR_W (0xFFFF+1 -> 0x0000).
REQ-024 Overlapping ranges SHALL be copied strictly forward, word by word, in address order; no overlap detection.
REQ-025 abort=1 in READ or WRITE SHALL return to IDLE at that posedge; a write in progress in that cycle completes; done SHALL NOT pulse; abort in IDLE/FINISH SHALL be ignored.
REQ-026 abort and start in the same IDLE cycle: start wins.
REQ-027 In IDLE, mem_write_enable=0 and mem_address/mem_write_data SHALL hold their last values.

Reset
REQ-028 reset_n low SHALL immediately force state IDLE, busy=0, done=0, mem_write_enable=0, mem_address=0, mem_write_data=0, counters and data register 0.
REQ-029 Reset during a transfer SHALL abandon it with no further writes and no done pulse.
REQ-030 First transfer SHALL be accepted at the first posedge after reset_n deasserts.

Configuration
REQ-031 Macro DMA_FILL_EN defined: additional inputs fill_mode (1 bit) and fill_value (DATA_W) sampled with start; fill_mode=1 skips READ, writes fill_value to consecutive dst addresses at 1 cycle per word (busy N+1 cycles), src ignored.
REQ-032 DMA_FILL_EN undefined: fill ports and fill logic absent; all transfers are copies.

Verification
REQ-033 Memory preloaded 0x0100..0x0103 = 1,2,3,4; start src=0x0100 dst=0x0200 length=4 -> 0x0200..0x0203 = 1,2,3,4, busy 9 cycles, one done pulse.
REQ-034 start length=0 -> done pulses 1 cycle later, mem_write_enable never asserted.
REQ-035 src=0xFFFF dst=0x0010 length=2, mem[0xFFFF]=0xAAAA mem[0x0000]=0x5555 -> mem[0x0010]=0xAAAA, mem[0x0011]=0x5555.
REQ-036 length=8 copy, abort asserted in 3rd WRITE -> exactly 3 destination words written, no done, busy low next cycle; start during transfer ignored.
REQ-037 reset_n pulsed low mid-transfer -> mem_write_enable low immediately, remaining destination words unchanged, no done.
REQ-038 DMA_FILL_EN defined: fill_mode=1 fill_value=0xBEEF dst=0x0300 length=3 -> 0x0300..0x0302 = 0xBEEF, busy 4 cycles.
